// File: rtl/seq_match_sched_if.sv
// Requester/consumer bundle for seq_match_sched.
// timeout_flag is only present when SEQ_MATCH_SCHED_TIMEOUT_EN is defined.
interface seq_match_sched_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 4
);
  localparam int IDW = $clog2(NREQ);

  logic                 cfg_we;
  logic [IDW-1:0]       cfg_id;
  logic [3:0]           cfg_num;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      in_valid;
  logic [NREQ*4-1:0]    in_seq;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic                 hit;
  logic [IDW-1:0]       hit_id;
  logic [CNT_W-1:0]     cnt;
  logic                 done;
`ifdef SEQ_MATCH_SCHED_TIMEOUT_EN
  logic                 timeout_flag;
`endif

  modport master (
    output cfg_we, cfg_id, cfg_num, req, in_valid, in_seq,
    input  grant, busy, hit, hit_id, cnt, done
`ifdef SEQ_MATCH_SCHED_TIMEOUT_EN
    , input timeout_flag
`endif
  );

  modport slave (
    input  cfg_we, cfg_id, cfg_num, req, in_valid, in_seq,
    output grant, busy, hit, hit_id, cnt, done
`ifdef SEQ_MATCH_SCHED_TIMEOUT_EN
    , output timeout_flag
`endif
  );
endinterface

// File: rtl/seq_match_sched.sv
// Round-robin scheduler sharing one nibble pattern-match counter among NREQ streams.
// Optional WATCH timeout enabled by defining SEQ_MATCH_SCHED_TIMEOUT_EN.
module seq_match_sched #(
  parameter int NREQ    = 4,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  seq_match_sched_if.slave   bus
);
  localparam int IDW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || CNT_W < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("seq_match_sched: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, WATCH, ASSERT} state_t;

  state_t             state_q;
  logic [IDW-1:0]     owner_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic [IDW-1:0]     rr_ptr_d;
  logic [NREQ-1:0]    grant_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic [3:0]         pat_q [NREQ];

  logic               win_found;
  logic [IDW-1:0]     win_id;
  int unsigned        idx;
  logic               own_valid;
  logic [3:0]         own_nib;
  logic               own_match;
  logic               timeout_hit;

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!win_found && bus.req[idx[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    own_valid = bus.in_valid[owner_q];
    own_nib   = bus.in_seq[{owner_q, 2'b00} +: 4];
    own_match = (own_nib == pat_q[owner_q]);
    rr_ptr_d  = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  end

`ifdef SEQ_MATCH_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt_q;
  logic          to_pend_q;
  logic          tflag_q;

  // Only a still-valid owner can be forced out; a dropping owner ends normally.
  assign timeout_hit = own_valid && (wcnt_q == TW'(TIMEOUT));
  assign bus.timeout_flag = tflag_q;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) pat_q[i] <= '0;
`ifdef SEQ_MATCH_SCHED_TIMEOUT_EN
      wcnt_q    <= '0;
      to_pend_q <= 1'b0;
      tflag_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SEQ_MATCH_SCHED_TIMEOUT_EN
      tflag_q <= 1'b0;
`endif
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (bus.cfg_we && bus.cfg_id == IDW'(i)) pat_q[i] <= bus.cfg_num;
      end

      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q <= WATCH;
            owner_q <= win_id;
            grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << win_id;
            cnt_q   <= '0;
`ifdef SEQ_MATCH_SCHED_TIMEOUT_EN
            wcnt_q    <= '0;
            to_pend_q <= 1'b0;
`endif
          end
        end

        WATCH: begin
          if (!own_valid || timeout_hit) begin
            if (cnt_q == '0) begin
              state_q  <= IDLE;
              grant_q  <= '0;
              done_q   <= 1'b1;
              rr_ptr_q <= rr_ptr_d;
`ifdef SEQ_MATCH_SCHED_TIMEOUT_EN
              tflag_q  <= timeout_hit;
`endif
            end else begin
              state_q <= ASSERT;
`ifdef SEQ_MATCH_SCHED_TIMEOUT_EN
              to_pend_q <= timeout_hit;
`endif
            end
          end else begin
            if (own_match && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
`ifdef SEQ_MATCH_SCHED_TIMEOUT_EN
            wcnt_q <= wcnt_q + 1'b1;
`endif
          end
        end

        ASSERT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= 1'b1;
            rr_ptr_q <= rr_ptr_d;
`ifdef SEQ_MATCH_SCHED_TIMEOUT_EN
            tflag_q  <= to_pend_q;
`endif
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant  = grant_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.hit    = (state_q == ASSERT);
  assign bus.hit_id = owner_q;
  assign bus.cnt    = cnt_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_seq_match_sched.sv
// Directed bench for seq_match_sched; timeout scenario runs when
// SEQ_MATCH_SCHED_TIMEOUT_EN is defined, saturation scenario otherwise.
module tb_seq_match_sched;
  localparam int NREQ  = 4;
  localparam int CNT_W = 4;
  localparam int IDW   = 2;
`ifdef SEQ_MATCH_SCHED_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 16;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  seq_match_sched_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

  seq_match_sched #(.NREQ(NREQ), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_pat(input logic [IDW-1:0] id, input logic [3:0] v);
    bus.cfg_we  = 1'b1;
    bus.cfg_id  = id;
    bus.cfg_num = v;
    tick();
    bus.cfg_we  = 1'b0;
  endtask

  task automatic grant_to(input logic [NREQ-1:0] r, input int unsigned id, input bit hold);
    bus.req = r;
    tick();
    check("grant", 32'(bus.grant), 32'(1) << id);
    check("busy_on", 32'(bus.busy), 1);
    check("cnt_start", 32'(bus.cnt), 0);
    check("done_clr", 32'(bus.done), 0);
    if (!hold) bus.req = '0;
  endtask

  // Nibble i of the stream is nibs[4i+3:4i]; other lanes are valid with
  // nibble 0 so any lane mix-up shows up as a wrong count.
  task automatic feed(input int unsigned id, input logic [79:0] nibs, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.in_valid = '1;
      bus.in_seq   = '0;
      bus.in_seq[id*4 +: 4] = nibs[i*4 +: 4];
      tick();
    end
    bus.in_valid = '0;
    bus.in_seq   = '0;
  endtask

  task automatic drain(input int unsigned id, input int unsigned hits_exp,
                       input bit skip_low, input bit tflag_exp);
    int unsigned n;
    n = 0;
    if (!skip_low) tick();
    for (int c = 0; c < 40 && bus.hit; c++) begin
      check("hit_id", 32'(bus.hit_id), id);
      check("cnt_dn", 32'(bus.cnt), hits_exp - n);
      n++;
      tick();
    end
    check("hits", n, hits_exp);
    check("done", 32'(bus.done), 1);
    check("done_id", 32'(bus.hit_id), id);
    check("grant_off", 32'(bus.grant), 0);
    check("busy_off", 32'(bus.busy), 0);
    check("cnt_end", 32'(bus.cnt), 0);
`ifdef SEQ_MATCH_SCHED_TIMEOUT_EN
    check("tflag", 32'(bus.timeout_flag), 32'(tflag_exp));
`else
    if (tflag_exp) check("tflag_unsupported", 0, 1);
`endif
  endtask

  initial begin
    bus.cfg_we   = 1'b0;
    bus.cfg_id   = '0;
    bus.cfg_num  = '0;
    bus.req      = '0;
    bus.in_valid = '0;
    bus.in_seq   = '0;

    reset = 1'b1;
    tick();
    tick();
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_hit", 32'(bus.hit), 0);
    check("rst_cnt", 32'(bus.cnt), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_hit_id", 32'(bus.hit_id), 0);
    reset = 1'b0;

    // Requester 1, pattern A, stream A,3,A,A -> 3 hits
    write_pat(2'd1, 4'hA);
    grant_to(4'b0010, 1, 1'b0);
    feed(1, 80'hAA3A, 4);
    check("cnt_peak_a", 32'(bus.cnt), 3);
    drain(1, 3, 1'b0, 1'b0);

    // rr_ptr is now 2: requesters 0 and 2 asking -> 2 wins; pat[2]=0, stream 0,0,9
    grant_to(4'b0101, 2, 1'b0);
    feed(2, 80'h900, 3);
    check("cnt_peak_b", 32'(bus.cnt), 2);
    drain(2, 2, 1'b0, 1'b0);

    // rr_ptr is now 3: pat[0]=5, stream 2,7 -> no match, straight to IDLE
    write_pat(2'd0, 4'h5);
    grant_to(4'b0001, 0, 1'b0);
    feed(0, 80'h72, 2);
    check("cnt_zero", 32'(bus.cnt), 0);
    drain(0, 0, 1'b0, 1'b0);

    // Reset in the middle of ASSERT with cnt=3
    grant_to(4'b0001, 0, 1'b0);
    feed(0, 80'h555, 3);
    tick();
    check("pre_rst_hit", 32'(bus.hit), 1);
    check("pre_rst_cnt", 32'(bus.cnt), 3);
    reset = 1'b1;
    tick();
    check("mid_rst_grant", 32'(bus.grant), 0);
    check("mid_rst_hit", 32'(bus.hit), 0);
    check("mid_rst_cnt", 32'(bus.cnt), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_hit_id", 32'(bus.hit_id), 0);
    reset = 1'b0;

    // All requesters held: grants 0,1,2,3,0; nibble 0 matches only if patterns were cleared
    for (int k = 0; k < 5; k++) begin
      grant_to(4'b1111, k % 4, 1'b1);
      feed(k % 4, 80'h0, 1);
      check("cnt_rr", 32'(bus.cnt), 1);
      drain(k % 4, 1, 1'b0, 1'b0);
    end
    bus.req = '0;

`ifdef SEQ_MATCH_SCHED_TIMEOUT_EN
    // TIMEOUT=4: owner stays valid and matching; fifth WATCH cycle forces exit uncounted
    grant_to(4'b0010, 1, 1'b0);
    feed(1, 80'h0, 4);
    check("cnt_pre_to", 32'(bus.cnt), 4);
    check("busy_pre_to", 32'(bus.busy), 1);
    bus.in_valid = '1;
    bus.in_seq   = '0;
    tick();
    check("forced_hit", 32'(bus.hit), 1);
    check("forced_cnt", 32'(bus.cnt), 4);
    drain(1, 4, 1'b1, 1'b1);
    bus.in_valid = '0;
`else
    // 20 matching nibbles saturate the counter at 15
    grant_to(4'b0010, 1, 1'b0);
    feed(1, 80'h0, 20);
    check("cnt_sat", 32'(bus.cnt), 15);
    drain(1, 15, 1'b0, 1'b0);
`endif

    tick();
    check("idle_done_clr", 32'(bus.done), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
